rv32i_alu: RTL and testbench
============================

Name: rv32i_alu

Overview:
- RV32I integer ALU for the execute stage of the riscv_32i core.
- Computes add/sub, logic, shift and set-less-than on two 32-bit operands, selected by a 4-bit alu_op_t code from riscv_32i_control_pkg.
- Drives a 32-bit result plus a zero flag consumed by branch logic.
- Outputs are registered: one clock of latency.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- SHAMT_W, 5, shift-amount width, equal to log2(XLEN).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- alu_op  input  4  operation select (alu_op_t).
- in_a  input  XLEN  operand A.
- in_b  input  XLEN  operand B; shift amount is in_b[SHAMT_W-1:0].
- result  output  XLEN  registered operation result.
- zero  output  1  registered flag: result equals 0 for a valid op.

Behaviour:
- Reset: on a rising clk with rst=1, result <= 0 and zero <= 0. Reset has priority over any input; inputs in that cycle are discarded.
- Latency: inputs sampled at rising clk N appear on result/zero after clk N, stable until clk N+1. Throughput is one operation per cycle. No handshake.
- Opcode encoding (alu_op_t):
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 SLT
  - 1001 SLTU
  - 1010-1111 invalid.
- ADD/SUB: modulo 2^32; wrap-around is silent with no carry or overflow output. SUB is in_a + ~in_b + 1.
- AND/OR/XOR: bitwise.
- SLL/SRL: logical shifts by in_b[4:0]; in_b[31:5] ignored. A shift of 0 passes in_a unchanged.
- SRA: arithmetic right shift, replicates in_a[31].
- SLT: result = {31'b0, signed(in_a) < signed(in_b)}.
- SLTU: result = {31'b0, in_a < in_b} unsigned.
- zero = 1 iff the op is valid and the computed result == 0.
- Invalid op: result = 0 and zero = 0 (zero is deliberately not asserted).
- X/unknown alu_op must not propagate X to the outputs; it is treated as invalid.
- Datapath is combinational into one output register; no other state.

Optional Feature:
- Macro: RV32I_ALU_ILLEGAL_OP_EN.
- When defined:
  - Adds output port illegal_op (1 bit), registered with the same latency.
  - illegal_op is 1 when the sampled alu_op is in 1010-1111.
  - Reset value is 0.
- When undefined: the port does not exist. result/zero behaviour is identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with alu_op=ADD, in_a=5, in_b=7 -> result=0, zero=0. Release rst -> next cycle result=12, zero=0.
- SUB corners:
  - 5-5 -> 0, zero=1.
  - 0-1 -> 0xFFFFFFFF, zero=0.
  - 0x80000000-1 -> 0x7FFFFFFF.
  - 0x7FFFFFFF-0xFFFFFFFF -> 0x80000000.
- ADD wrap: 0xFFFFFFFF+1 -> 0, zero=1.
- Shifts:
  - SLL 1 by in_b=0x21 (shamt 1) -> 2.
  - SRL 0x80000000 by 31 -> 1.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - Any shift of in_a=0xDEADBEEF by 0 -> 0xDEADBEEF.
- Compares:
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU 0xFFFFFFFF,1 -> 0, zero=1.
  - SLT 3,3 -> 0, zero=1.
- Invalid and back-to-back:
  - alu_op=1111, in_a=in_b=0 -> result=0, zero=0 (illegal_op=1 when RV32I_ALU_ILLEGAL_OP_EN is defined).
  - Back-to-back ops on consecutive cycles: AND 0xF0F0F0F0,0x0F0F0F0F -> 0, zero=1; then OR of the same operands -> 0xFFFFFFFF. Each result appears exactly one cycle after its inputs.

Source files
------------

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: add/sub, logic, shifts, set-less-than, registered result and zero flag.
// Optional RV32I_ALU_ILLEGAL_OP_EN adds a registered illegal_op output for opcodes 1010-1111.
module rv32i_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] result,
  output logic            zero
`ifdef RV32I_ALU_ILLEGAL_OP_EN
  ,
  output logic            illegal_op
`endif
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    res_next;
  logic               valid;

  assign shamt = in_b[SHAMT_W-1:0];

  // Unknown or unused opcodes land in the default arm, so X never reaches the registers.
  always_comb begin
    res_next = '0;
    valid    = 1'b1;
    case (alu_op)
      OP_ADD:  res_next = in_a + in_b;
      OP_SUB:  res_next = in_a + ~in_b + XLEN'(1);
      OP_AND:  res_next = in_a & in_b;
      OP_OR:   res_next = in_a | in_b;
      OP_XOR:  res_next = in_a ^ in_b;
      OP_SLL:  res_next = in_a << shamt;
      OP_SRL:  res_next = in_a >> shamt;
      OP_SRA:  res_next = $unsigned($signed(in_a) >>> shamt);
      OP_SLT:  res_next = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: res_next = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: begin
        res_next = '0;
        valid    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
    end else begin
      result <= res_next;
      zero   <= valid && (res_next == '0);
    end
  end

`ifdef RV32I_ALU_ILLEGAL_OP_EN
  always_ff @(posedge clk) begin
    if (rst) illegal_op <= 1'b0;
    else     illegal_op <= ~valid;
  end
`endif

endmodule

// File: tb/tb_rv32i_alu.sv
// Scoreboard bench for rv32i_alu: expectations queued at drive time, compared one cycle later.
// Checks illegal_op as well when RV32I_ALU_ILLEGAL_OP_EN is defined.
module tb_rv32i_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_op;
  logic [31:0] in_a, in_b;
  logic [31:0] result;
  logic        zero;
`ifdef RV32I_ALU_ILLEGAL_OP_EN
  logic        illegal_op;
`endif

  rv32i_alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .alu_op(alu_op),
    .in_a(in_a),
    .in_b(in_b),
    .result(result),
    .zero(zero)
`ifdef RV32I_ALU_ILLEGAL_OP_EN
    ,
    .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zf;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference model, written independently of the RTL datapath.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic ill);
    int unsigned s;
    s   = b % 32;
    ill = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << s;
      4'd6: r = a >> s;
      4'd7: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'h0; ill = 1'b1; end
    endcase
    z = !ill && (r == 32'h0);
  endfunction

  task automatic compare_head();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_eq({e.tag, ".result"}, result, e.res);
    check_eq({e.tag, ".zero"}, {31'b0, zero}, {31'b0, e.zf});
`ifdef RV32I_ALU_ILLEGAL_OP_EN
    check_eq({e.tag, ".illegal_op"}, {31'b0, illegal_op}, {31'b0, e.ill});
`endif
  endtask

  // One cycle: compare the previous op's output, then drive the next op and queue its expectation.
  task automatic step(input string tag, input logic r, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ez, input logic ei);
    exp_t e;
    @(negedge clk);
    compare_head();
    rst = r; alu_op = op; in_a = a; in_b = b;
    e.tag = tag; e.res = er; e.zf = ez; e.ill = ei;
    exp_q.push_back(e);
  endtask

  task automatic step_model(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic z, ill;
    model(op, a, b, r, z, ill);
    step(tag, 1'b0, op, a, b, r, z, ill);
  endtask

  initial begin
    rst = 1'b1; alu_op = 4'd0; in_a = 32'd5; in_b = 32'd7;
    step("rst0", 1'b1, 4'd0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0);
    step("rst1", 1'b1, 4'd0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0);
    step("add_after_rst", 1'b0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

    step("sub_5_5",   1'b0, 4'd1, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    step("sub_0_1",   1'b0, 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step("sub_min_1", 1'b0, 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    step("sub_max_m1",1'b0, 4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    step("add_wrap",  1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0);

    step("sll_shamt1", 1'b0, 4'd5, 32'd1, 32'h21, 32'd2, 1'b0, 1'b0);
    step("srl_31",     1'b0, 4'd6, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0);
    step("sra_4",      1'b0, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
    step("sll_0",      1'b0, 4'd5, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step("srl_0",      1'b0, 4'd6, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step("sra_0",      1'b0, 4'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    step("slt_neg1_1",  1'b0, 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    step("sltu_max_1",  1'b0, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    step("slt_3_3",     1'b0, 4'd8, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);

    step("invalid_f",   1'b0, 4'hF, 32'd0, 32'd0, 32'h0, 1'b0, 1'b1);
    step("invalid_a",   1'b0, 4'hA, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b1);

    step("b2b_and", 1'b0, 4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1'b1, 1'b0);
    step("b2b_or",  1'b0, 4'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step("xor",     1'b0, 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);

    // Reset mid-stream discards the op sampled in that cycle.
    step("rst_mid", 1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      step_model($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    @(negedge clk);
    compare_head();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
